// File: rtl/if_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_pkg
// Description : Shared definitions for the instruction-fetch prefetch stage.
//               Provides the machine word width (`XLEN), the NOP encoding,
//               the default reset PC, the {pc, inst} buffer entry type and a
//               word-alignment helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif

package if_prefetch_pkg;

    localparam int XLEN = `XLEN;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSN         = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    localparam logic [XLEN-1:0] PC_STEP          = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Clear the two byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_prefetch_if.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_if
// Description : Bundle of the fetch stage's memory handshake and decode-side
//               signals.
//               master : the fetch stage (drives imem request, decode outputs)
//               slave  : the environment (instruction memory + decode/execute)
// Signals     : imem_req_o/imem_addr_o, imem_gnt_i, imem_rvalid_i/imem_rdata_i,
//               stall_i, redirect_i/redirect_pc_i, valid_o/pc_o/inst_o
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif

interface if_prefetch_if;

    logic              imem_req_o;
    logic [`XLEN-1:0]  imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [`XLEN-1:0]  imem_rdata_i;
    logic              stall_i;
    logic              redirect_i;
    logic [`XLEN-1:0]  redirect_pc_i;
    logic              valid_o;
    logic [`XLEN-1:0]  pc_o;
    logic [`XLEN-1:0]  inst_o;

    modport master (
        output imem_req_o, imem_addr_o, valid_o, pc_o, inst_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
               stall_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, valid_o, pc_o, inst_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
               stall_i, redirect_i, redirect_pc_i
    );

endinterface

`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
// Module      : if_fifo
// Description : DEPTH x WIDTH synchronous in-order FIFO with flush.
//               Flush has priority over push/pop and resets both pointers.
//               DEPTH must be a power of two so the pointers wrap naturally.
// Ports       : clk_i, rst_i (async, active-high)
//               flush_i, push_i, wdata_i, pop_i
//               rdata_o (head entry), count_o (0..DEPTH), empty_o
// Revision    : 1.0 - initial release
// ============================================================================
module if_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count_q == CW'(DEPTH));
        do_push = push_i && !flush_i;
        do_pop  = pop_i && !flush_i && (count_q != '0);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The upstream credit scheme must never let a word arrive with no room.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(do_push && full))
                else $error("if_fifo: push onto a full FIFO");
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch
// Description : Instruction-fetch stage feeding decode. Issues sequential
//               word fetches over a req/gnt/rvalid memory port, buffers the
//               in-order responses with their PCs and presents the oldest
//               one to decode. A redirect from execute retargets fetch,
//               flushes the buffer and discards every in-flight response.
// Ports       : clk_i, rst_i (async, active-high)
//               bus (if_prefetch_if.master):
//                 imem_req_o/imem_addr_o/imem_gnt_i   - request channel
//                 imem_rvalid_i/imem_rdata_i          - in-order responses
//                 stall_i, redirect_i/redirect_pc_i   - pipeline control
//                 valid_o/pc_o/inst_o                 - instruction to decode
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter logic [`XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int               DEPTH    = 2,   // power of two, >= 2
    parameter logic [`XLEN-1:0] NOP      = NOP_INSN
) (
    input  logic          clk_i,
    input  logic          rst_i,
    if_prefetch_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   outstanding_after_rv;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] redirect_tgt;
    logic            imem_req;
    logic            accept;
    logic            push;
    logic            pop;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic [2*XLEN-1:0] head_raw;

    // ------------------------------------------------------------------
    // Request side: in-flight requests plus buffered words never exceed
    // DEPTH, so every response is guaranteed a buffer slot.
    // ------------------------------------------------------------------
    always_comb begin
        credit_used  = (CW+1)'(outstanding_q) + (CW+1)'(fifo_count);
        imem_req     = !rst_i && !bus.redirect_i && (credit_used < (CW+1)'(DEPTH));
        accept       = imem_req && bus.imem_gnt_i;
        redirect_tgt = align_word(bus.redirect_pc_i);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        outstanding_after_rv = outstanding_q - CW'(bus.imem_rvalid_i);

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_after_rv + CW'(accept);
        push          = 1'b0;

        if (bus.redirect_i) begin
            // Everything still in flight belongs to the abandoned path.
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            discard_d  = outstanding_after_rv;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (bus.imem_rvalid_i) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + PC_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer
    // ------------------------------------------------------------------
    always_comb begin
        push_entry.pc   = resp_pc_q;
        push_entry.inst = bus.imem_rdata_i;
        // A redirect flushes the buffer, so nothing is handed to decode then.
        pop             = !fifo_empty && !bus.stall_i && !bus.redirect_i;
        head_entry      = fetch_entry_t'(head_raw);
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bus.redirect_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_raw),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Outputs. With an empty buffer, pc_o shows where the next word will
    // come from rather than a stale head.
    // ------------------------------------------------------------------
    assign bus.imem_req_o  = imem_req;
    assign bus.imem_addr_o = fetch_pc_q;
    assign bus.valid_o     = !fifo_empty;
    assign bus.pc_o        = fifo_empty ? resp_pc_q : head_entry.pc;
    assign bus.inst_o      = fifo_empty ? NOP : head_entry.inst;

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch
// Description : Self-checking bench for if_prefetch. A memory responder with
//               random grant/latency feeds the stage; the reference model is
//               the architectural instruction stream: decode must see
//               consecutive PCs from the last redirect target, each paired
//               with the memory word at that PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } pend_t;

    logic clk;
    logic rst;

    if_prefetch_if bus ();

    if_prefetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP      (NOP)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    int          cyc;
    int          pops;
    pend_t       pending [$];
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic        last_valid;
    logic        last_req;
    logic [31:0] last_pc;
    logic [31:0] last_inst;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
            else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later,
    // then advance the model to what the next rising edge must produce.
    task automatic step(input logic g, input logic st, input logic rd,
                        input logic [31:0] tgt, input logic hold_rv, input int lat);
        logic        rv;
        logic [31:0] rv_addr;
        pend_t       p;
        @(negedge clk);
        rv      = 1'b0;
        rv_addr = '0;
        if (!hold_rv && pending.size() > 0 && pending[0].ready <= cyc) begin
            p       = pending.pop_front();
            rv      = 1'b1;
            rv_addr = p.addr;
        end
        bus.imem_gnt_i    = g;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rv ? memword(rv_addr) : $urandom;
        bus.stall_i       = st;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = tgt;
        #1;
        last_valid = bus.valid_o;
        last_req   = bus.imem_req_o;
        last_pc    = bus.pc_o;
        last_inst  = bus.inst_o;

        if (rd) chk("req_in_redirect", {31'd0, bus.imem_req_o}, 32'd0);
        if (prev_wait && !rd) begin
            chk("req_held_until_gnt", {31'd0, bus.imem_req_o}, 32'd1);
            chk("addr_held_until_gnt", bus.imem_addr_o, prev_addr);
        end
        if (bus.imem_req_o) chk("fetch_addr", bus.imem_addr_o, exp_fetch);

        if (bus.valid_o) begin
            chk("decode_pc", bus.pc_o, exp_pc);
            chk("decode_inst", bus.inst_o, memword(exp_pc));
            if (!st && !rd) begin
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end else begin
            chk("empty_inst_nop", bus.inst_o, NOP);
            chk("empty_pc_next", bus.pc_o, exp_pc);
        end

        if (bus.imem_req_o && g) begin
            p.addr  = exp_fetch;
            p.ready = cyc + lat;
            pending.push_back(p);
            exp_fetch = exp_fetch + 32'd4;
        end
        chk("credit_limit", {31'd0, pending.size() <= DEPTH}, 32'd1);

        if (rd) begin
            exp_pc    = {tgt[31:2], 2'b00};
            exp_fetch = {tgt[31:2], 2'b00};
        end
        prev_wait = bus.imem_req_o && !g && !rd;
        prev_addr = bus.imem_addr_o;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string phase);
        chk({phase, "_req"},   {31'd0, bus.imem_req_o}, 32'd0);
        chk({phase, "_addr"},  bus.imem_addr_o, RESET_PC);
        chk({phase, "_valid"}, {31'd0, bus.valid_o}, 32'd0);
        chk({phase, "_pc"},    bus.pc_o, RESET_PC);
        chk({phase, "_inst"},  bus.inst_o, NOP);
    endtask

    task automatic model_reset();
        pending.delete();
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        prev_wait = 1'b0;
        prev_addr = RESET_PC;
    endtask

    initial begin
        int          hold8;
        int          n;
        int          pops_before;
        logic        g;
        logic        seen;
        logic [31:0] first_pc;

        checks = 0;
        errors = 0;
        cyc    = 0;
        pops   = 0;
        model_reset();
        rst = 1'b1;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;

        // Reset values
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // Streaming with zero-wait grant; grant for address 8 held back 3 cycles
        hold8 = 0;
        for (int i = 0; i < 14; i++) begin
            g = 1'b1;
            if (exp_fetch == 32'h8 && hold8 < 3) begin
                g = 1'b0;
                hold8++;
            end
            step(g, 1'b0, 1'b0, '0, 1'b0, 1);
            if (i < 2)  chk("first_valid_not_yet", {31'd0, last_valid}, 32'd0);
            if (i == 2) chk("first_valid_cycle2", {31'd0, last_valid}, 32'd1);
        end

        // Decode stall: request must stop once the buffer is full
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1);
        chk("stall_req_low", {31'd0, last_req}, 32'd0);
        chk("stall_valid_held", {31'd0, last_valid}, 32'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1);

        // Redirect to an unaligned target with two requests in flight
        n = 0;
        while (pending.size() < 2 && n < 10) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b0, 4);
            n++;
        end
        chk("two_outstanding", pending.size(), 32'd2);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 1);
        seen = 1'b0;
        first_pc = '0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1);
            if (last_valid && !seen) begin
                seen     = 1'b1;
                first_pc = last_pc;
            end
        end
        chk("redirect_first_pc", first_pc, 32'h0000_0100);

        // Redirect coinciding with a response and an offered grant
        n = 0;
        while (!(pending.size() > 0 && pending[0].ready <= cyc) && n < 10) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b0, 2);
            n++;
        end
        chk("response_due_at_redirect", {31'd0, pending.size() > 0 && pending[0].ready <= cyc}, 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1);
        chk("redirect_rv_req_low", {31'd0, last_req}, 32'd0);
        seen = 1'b0;
        first_pc = '0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1);
            if (last_valid && !seen) begin
                seen     = 1'b1;
                first_pc = last_pc;
            end
        end
        chk("redirect_rv_first_pc", first_pc, 32'h0000_0200);

        // Responses withheld: buffer drains and NOP is presented
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1);
        chk("empty_valid_low", {31'd0, last_valid}, 32'd0);
        chk("empty_inst_is_nop", last_inst, NOP);
        chk("empty_req_blocked", {31'd0, last_req}, 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1);

        // Randomised traffic
        pops_before = pops;
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 23) == 0,
                 $urandom, ($urandom % 6) == 0, 1 + int'($urandom % 3));
        end
        chk("random_progress", {31'd0, (pops - pops_before) > 20}, 32'd1);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1);
        chk("post_reset_stream", {31'd0, exp_pc != RESET_PC}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
